// File: rtl/ahb_lite_cmd_master.sv
// ahb_lite_cmd_master: valid/ready command stream to pipelined AHB-Lite NONSEQ word transfers
module ahb_lite_cmd_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic [1:0]        HRESP
);
    logic              a_valid_q, a_valid_d;
    logic              a_write_q, a_write_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
    logic              d_valid_q, d_valid_d;
    logic              d_write_q, d_write_d;
    logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              accept;
    logic              done;

    assign cmd_ready = !HRESET & (!a_valid_q | HREADY);
    assign accept    = cmd_valid & cmd_ready;
    assign done      = HREADY & d_valid_q;

    assign HTRANS    = a_valid_q ? 2'b10 : 2'b00;
    assign HSEL      = a_valid_q;
    assign HADDR     = a_addr_q;
    assign HWRITE    = a_write_q;
    assign HSIZE     = 3'b010;
    assign HWDATA    = d_wdata_q;
    assign busy      = a_valid_q | d_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    // Pipeline advance: D takes A on HREADY, A loads an accepted command or empties
    always_comb begin
        a_valid_d = a_valid_q;
        a_write_d = a_write_q;
        a_addr_d  = a_addr_q;
        a_wdata_d = a_wdata_q;
        d_valid_d = d_valid_q;
        d_write_d = d_write_q;
        d_wdata_d = d_wdata_q;
        if (HREADY) begin
            d_valid_d = a_valid_q;
            d_write_d = a_write_q;
            d_wdata_d = a_wdata_q;
            a_valid_d = 1'b0;
        end
        if (accept) begin
            a_valid_d = 1'b1;
            a_write_d = cmd_write;
            a_addr_d  = cmd_addr & ~ADDR_W'(3);
            a_wdata_d = cmd_wdata;
        end
    end

    // Response for the data phase completing this edge; rdata is zero for writes
    always_comb begin
        rsp_valid_d = done;
        rsp_err_d   = done & (HRESP != 2'b00);
        rsp_rdata_d = (done & !d_write_q) ? HRDATA : '0;
    end

    // State registers; reset drops any in-flight transfer without a response
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_valid_q   <= 1'b0;
            a_write_q   <= 1'b0;
            a_addr_q    <= '0;
            a_wdata_q   <= '0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_wdata_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_write_q   <= a_write_d;
            a_addr_q    <= a_addr_d;
            a_wdata_q   <= a_wdata_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            d_wdata_q   <= d_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end
endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// tb_ahb_lite_cmd_master: directed cycle-accurate checks of the AHB-Lite command master
module tb_ahb_lite_cmd_master;
    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        HSEL, HWRITE, HREADY;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS, HRESP;
    logic [2:0]  HSIZE;
    int          vectors = 0;
    int          miscompares = 0;

    logic [31:0] mem [16];
    logic        s_valid, s_write;
    logic [3:0]  s_addr;

    ahb_lite_cmd_master dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Memory slave stub: HREADY/HRESP come from the tests, data follows the pipeline
    always @(posedge HCLK) begin
        if (HRESET) s_valid <= 1'b0;
        else if (HREADY) begin
            if (s_valid && s_write) mem[s_addr] <= HWDATA;
            s_valid <= HTRANS[1];
            s_write <= HWRITE;
            s_addr  <= HADDR[5:2];
        end
    end
    assign HRDATA = (s_valid && !s_write) ? mem[s_addr] : 32'h0;

    task automatic nxt;
        @(negedge HCLK);
    endtask

    task automatic test_reset;
        HRESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; HREADY = 1; HRESP = 0;
        nxt; #1;
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_in_reset got %b want 0", cmd_ready); end
        nxt; HRESET = 0;
        vectors++; if (HTRANS !== 2'b00) begin miscompares++; $display("FAIL rst_htrans got %b want 00", HTRANS); end
        vectors++; if (HSEL !== 1'b0) begin miscompares++; $display("FAIL rst_hsel got %b want 0", HSEL); end
        vectors++; if (HADDR !== 32'h0) begin miscompares++; $display("FAIL rst_haddr got %h want 0", HADDR); end
        vectors++; if (HWDATA !== 32'h0) begin miscompares++; $display("FAIL rst_hwdata got %h want 0", HWDATA); end
        vectors++; if (HWRITE !== 1'b0) begin miscompares++; $display("FAIL rst_hwrite got %b want 0", HWRITE); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        vectors++; if (HSIZE !== 3'b010) begin miscompares++; $display("FAIL rst_hsize got %b want 010", HSIZE); end
        #1;
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_idle got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_read;
        nxt; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hB; cmd_wdata = 32'hA5A5A5A5; #1;
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready got %b want 1", cmd_ready); end
        nxt;
        vectors++; if (HTRANS !== 2'b10) begin miscompares++; $display("FAIL wr_htrans got %b want 10", HTRANS); end
        vectors++; if (HSEL !== 1'b1) begin miscompares++; $display("FAIL wr_hsel got %b want 1", HSEL); end
        vectors++; if (HADDR !== 32'h8) begin miscompares++; $display("FAIL wr_haddr got %h want 8", HADDR); end
        vectors++; if (HWRITE !== 1'b1) begin miscompares++; $display("FAIL wr_hwrite got %b want 1", HWRITE); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy got %b want 1", busy); end
        cmd_write = 0; cmd_addr = 32'h8;
        nxt;
        vectors++; if (HWDATA !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL wr_hwdata got %h want a5a5a5a5", HWDATA); end
        vectors++; if (HWRITE !== 1'b0) begin miscompares++; $display("FAIL rd_hwrite got %b want 0", HWRITE); end
        vectors++; if (HTRANS !== 2'b10) begin miscompares++; $display("FAIL rd_htrans got %b want 10", HTRANS); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_early got %b want 0", rsp_valid); end
        cmd_valid = 0;
        nxt;
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL wr_rsp_valid got %b want 1", rsp_valid); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_err got %b want 0", rsp_err); end
        vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL wr_rsp_rdata got %h want 0", rsp_rdata); end
        vectors++; if (HTRANS !== 2'b00) begin miscompares++; $display("FAIL wr_htrans_idle got %b want 00", HTRANS); end
        nxt;
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rd_rsp_valid got %b want 1", rsp_valid); end
        vectors++; if (rsp_rdata !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL rd_rsp_rdata got %h want a5a5a5a5", rsp_rdata); end
        nxt;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_rsp_end got %b want 0", rsp_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_busy_end got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        nxt; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0; cmd_wdata = 32'h10;
        for (int j = 1; j <= 7; j++) begin
            nxt;
            vectors++; if (HTRANS !== ((j <= 4) ? 2'b10 : 2'b00)) begin miscompares++; $display("FAIL b2b_htrans cycle %0d got %b", j, HTRANS); end
            if (j <= 4) begin
                vectors++; if (HADDR !== 32'(4 * (j - 1))) begin miscompares++; $display("FAIL b2b_haddr cycle %0d got %h want %h", j, HADDR, 4 * (j - 1)); end
            end
            if (j >= 2 && j <= 5) begin
                vectors++; if (HWDATA !== 32'(32'h10 + j - 2)) begin miscompares++; $display("FAIL b2b_hwdata cycle %0d got %h want %h", j, HWDATA, 32'h10 + j - 2); end
            end
            vectors++; if (rsp_valid !== (j >= 3 && j <= 6)) begin miscompares++; $display("FAIL b2b_rsp_valid cycle %0d got %b", j, rsp_valid); end
            if (j < 4) begin cmd_addr = 32'(4 * j); cmd_wdata = 32'(32'h10 + j); end
            else cmd_valid = 0;
        end
    endtask

    task automatic test_wait_states;
        nxt; cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h4;
        nxt;
        vectors++; if (HADDR !== 32'h4) begin miscompares++; $display("FAIL ws_haddr_rd got %h want 4", HADDR); end
        cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'hCAFE0002;
        nxt;
        cmd_write = 0; cmd_addr = 32'h20; HREADY = 0; #1;
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL ws_ready_1 got %b want 0", cmd_ready); end
        for (int k = 0; k < 2; k++) begin
            nxt;
            vectors++; if (HADDR !== 32'h20) begin miscompares++; $display("FAIL ws_haddr_hold %0d got %h want 20", k, HADDR); end
            vectors++; if (HTRANS !== 2'b10) begin miscompares++; $display("FAIL ws_htrans_hold %0d got %b want 10", k, HTRANS); end
            vectors++; if (HWRITE !== 1'b1) begin miscompares++; $display("FAIL ws_hwrite_hold %0d got %b want 1", k, HWRITE); end
            vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ws_rsp_hold %0d got %b want 0", k, rsp_valid); end
            if (k == 0) begin
                #1;
                vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL ws_ready_2 got %b want 0", cmd_ready); end
            end else HREADY = 1;
        end
        #1;
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ws_ready_release got %b want 1", cmd_ready); end
        nxt;
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL ws_rd_rsp got %b want 1", rsp_valid); end
        vectors++; if (rsp_rdata !== 32'h11) begin miscompares++; $display("FAIL ws_rd_rdata got %h want 11", rsp_rdata); end
        vectors++; if (HWDATA !== 32'hCAFE0002) begin miscompares++; $display("FAIL ws_hwdata got %h want cafe0002", HWDATA); end
        vectors++; if (HWRITE !== 1'b0) begin miscompares++; $display("FAIL ws_hwrite_rd2 got %b want 0", HWRITE); end
        cmd_valid = 0;
        nxt;
        vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL ws_wr_rsp got %b/%h want 1/0", rsp_valid, rsp_rdata); end
        nxt;
        vectors++; if (rsp_rdata !== 32'hCAFE0002) begin miscompares++; $display("FAIL ws_rd2_rdata got %h want cafe0002", rsp_rdata); end
        nxt;
        vectors++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ws_idle got busy %b rsp %b want 0 0", busy, rsp_valid); end
    endtask

    task automatic test_error;
        nxt; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'h1;
        nxt; cmd_addr = 32'h34; cmd_wdata = 32'h2;
        nxt; cmd_addr = 32'h38; cmd_wdata = 32'h3;
        nxt;
        vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL err_first_rsp got %b/%b want 1/0", rsp_valid, rsp_err); end
        cmd_valid = 0; HREADY = 0; HRESP = 2'b01;
        nxt;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL err_wait_rsp got %b want 0", rsp_valid); end
        vectors++; if (HADDR !== 32'h38 || HTRANS !== 2'b10) begin miscompares++; $display("FAIL err_third_pending got %h/%b want 38/10", HADDR, HTRANS); end
        HREADY = 1;
        nxt;
        vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin miscompares++; $display("FAIL err_second_rsp got %b/%b want 1/1", rsp_valid, rsp_err); end
        vectors++; if (HWDATA !== 32'h3) begin miscompares++; $display("FAIL err_third_issued got %h want 3", HWDATA); end
        HRESP = 2'b00;
        nxt;
        vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL err_third_rsp got %b/%b want 1/0", rsp_valid, rsp_err); end
        nxt;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL err_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        nxt; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h8; cmd_wdata = 32'hDEAD0001;
        nxt; cmd_write = 0; cmd_addr = 32'h4;
        nxt; cmd_valid = 0; HRESET = 1; #1;
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL mr_ready got %b want 0", cmd_ready); end
        nxt; HRESET = 0;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mr_rsp got %b want 0", rsp_valid); end
        vectors++; if (HTRANS !== 2'b00 || HSEL !== 1'b0) begin miscompares++; $display("FAIL mr_htrans got %b/%b want 00/0", HTRANS, HSEL); end
        vectors++; if (HADDR !== 32'h0 || HWDATA !== 32'h0 || HWRITE !== 1'b0) begin miscompares++; $display("FAIL mr_bus got %h/%h/%b want 0/0/0", HADDR, HWDATA, HWRITE); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mr_busy got %b want 0", busy); end
        nxt;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mr_no_rsp got %b want 0", rsp_valid); end
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8;
        nxt; cmd_valid = 0;
        nxt;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mr_rd_early got %b want 0", rsp_valid); end
        nxt;
        vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12) begin miscompares++; $display("FAIL mr_rd_rsp got %b/%h want 1/12", rsp_valid, rsp_rdata); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_back_to_back;
        test_wait_states;
        test_error;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
